// File: rtl/div_unit.sv
// -----------------------------------------------------------------------------
// div_unit: multi-cycle 32-bit integer divider (signed and unsigned).
// A restoring radix-2 divider that takes one shift/subtract step per cycle.
// A non-zero divisor takes 32 steps, then the result is presented in DONE.
// A zero divisor goes straight to DONE with quotient all-ones and remainder a.
//
// Ports
//   clk        : clock, rising edge
//   rst        : asynchronous active-low reset
//   start      : request a divide (sampled in IDLE only)
//   signed_div : 1 = signed divide, 0 = unsigned divide
//   a, b       : dividend and divisor, captured when the request is accepted
//   annul      : abort the divide in flight; blocks capture in IDLE
//   stall      : combinational; holds the upstream pipeline while a divide runs
//   ready      : one-cycle pulse; result is valid in this cycle
//   result     : {remainder, quotient}, held stable between ready pulses
// -----------------------------------------------------------------------------
module div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        signed_div,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        annul,
  output logic        stall,
  output logic        ready,
  output logic [63:0] result
);

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2*DW-1:0]   acc_q, acc_d;
  logic [DW-1:0]     div_q, div_d;
  logic              quo_neg_q, quo_neg_d;
  logic              rem_neg_q, rem_neg_d;
  logic [2*DW-1:0]   result_q, result_d;
  logic              ready_q, ready_d;

  logic              sign_a, sign_b;
  logic [DW-1:0]     mag_a, mag_b;
  logic [DW:0]       diff;
  logic              ge;
  logic [2*DW-1:0]   step_acc;
  logic [DW-1:0]     quo_fix, rem_fix;

  // Operand magnitudes; only the signed divide treats bit 31 as a sign.
  always_comb begin
    sign_a = signed_div & a[DW-1];
    sign_b = signed_div & b[DW-1];
    mag_a  = sign_a ? (~a + DW'(1)) : a;
    mag_b  = sign_b ? (~b + DW'(1)) : b;
  end

  // One restoring step. The 33-bit partial remainder includes the bit shifted
  // out of the top of acc, so the compare stays exact for divisors >= 2^31.
  always_comb begin
    diff     = acc_q[2*DW-1:DW-1] - {1'b0, div_q};
    ge       = ~diff[DW];
    step_acc = ge ? {diff[DW-1:0], acc_q[DW-2:0], 1'b1}
                  : {acc_q[2*DW-2:0], 1'b0};
    quo_fix  = quo_neg_q ? (~step_acc[DW-1:0] + DW'(1)) : step_acc[DW-1:0];
    rem_fix  = rem_neg_q ? (~step_acc[2*DW-1:DW] + DW'(1)) : step_acc[2*DW-1:DW];
  end

  // Next-state and datapath control.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    div_d     = div_q;
    quo_neg_d = quo_neg_q;
    rem_neg_d = rem_neg_q;
    result_d  = result_q;
    ready_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start && !annul) begin
          div_d     = mag_b;
          quo_neg_d = sign_a ^ sign_b;
          rem_neg_d = sign_a;
          acc_d     = {DW'(0), mag_a};
          cnt_d     = CW'(0);
          if (b == DW'(0)) begin
            state_d  = DONE;
            result_d = {a, {DW{1'b1}}};
            ready_d  = 1'b1;
          end else begin
            state_d  = BUSY;
          end
        end
      end
      BUSY: begin
        if (annul) begin
          state_d = IDLE;
        end else begin
          acc_d = step_acc;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == {CW{1'b1}}) begin
            state_d  = DONE;
            result_d = {rem_fix, quo_fix};
            ready_d  = 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      div_q     <= '0;
      quo_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      result_q  <= '0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      div_q     <= div_d;
      quo_neg_q <= quo_neg_d;
      rem_neg_q <= rem_neg_d;
      result_q  <= result_d;
      ready_q   <= ready_d;
    end
  end

  // Stall covers the accepting cycle too; gated by rst so it drops immediately.
  always_comb begin
    stall = rst & (((state_q == IDLE) & start & ~annul) | (state_q == BUSY));
  end

  assign ready  = ready_q;
  assign result = result_q;

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-002 SHALL have port rst, input, 1 bit: asynchronous, active-low reset; rst=0 forces the reset state immediately, independent of clk.
REQ-003 SHALL have port start, input, 1 bit: request a divide; driven by the execute-stage div control bit (divE).
REQ-004 SHALL have port signed_div, input, 1 bit: 1 selects signed (div), 0 selects unsigned (divu); driven by hassignE.
REQ-005 SHALL have port a, input, 32 bits: dividend.
REQ-006 SHALL have port b, input, 32 bits: divisor.
REQ-007 SHALL have port annul, input, 1 bit: abort the operation in flight (pipeline flush or exception).
REQ-008 SHALL have port stall, output, 1 bit: freezes the upstream pipeline while a divide is in progress.
REQ-009 SHALL have port ready, output, 1 bit: one-cycle pulse marking result as valid.
REQ-010 SHALL have port result, output, 64 bits: {remainder[63:32] → HI, quotient[31:0] → LO}.

Function
REQ-011 SHALL implement the FSM states IDLE, BUSY and DONE.
REQ-012 SHALL, in IDLE with start=1 and annul=0, latch a, b and signed_div, and take the next state as follows:
- b=0: DONE
- b≠0: BUSY, with the iteration counter cleared to 0.
REQ-013 SHALL ignore changes on a, b and signed_div after the capture in REQ-012.
REQ-014 SHALL ignore start while in BUSY or DONE.
REQ-015 SHALL, in BUSY, perform one restoring radix-2 shift/subtract step per cycle on the operand magnitudes, for exactly 32 cycles (counter 0..31).
REQ-016 SHALL go from BUSY to DONE on the cycle after counter=31.
REQ-017 SHALL, in DONE, drive ready=1 with result valid for exactly that one cycle, then return to IDLE unconditionally.
REQ-018 SHALL give a non-zero-divisor latency of 33 cycles: ready is high in the 33rd cycle after the edge that sampled start.
REQ-019 SHALL give a zero-divisor latency of 1 cycle: ready is high in the cycle after the start edge.
REQ-020 SHALL drive stall = (IDLE & start & ~annul) | BUSY; stall SHALL be low in DONE so the pipeline advances on the ready cycle.
REQ-021 SHALL, for signed operands, take magnitudes by two's-complement negation of negative inputs.
REQ-022 SHALL, for signed operands, negate the quotient when sign(a)≠sign(b) and give the remainder the sign of a.
REQ-023 SHALL, for signed -2^31 / -1, return quotient 0x80000000 and remainder 0 (wrap, no trap).
REQ-024 SHALL, for b=0 (signed or unsigned), return quotient 0xFFFFFFFF and remainder a.
REQ-025 SHALL, when annul=1 in BUSY, go to IDLE on the next edge with no ready pulse; result SHALL keep its previous value.
REQ-026 SHALL give annul priority over start in IDLE: no capture, stall=0.
REQ-027 SHALL, when annul=1 in DONE, still pulse ready; the consumer is responsible for gating the HI/LO write.
REQ-028 SHALL hold result stable between ready pulses; it updates only on entry to DONE.
REQ-029 SHALL use arithmetic widths of a 64-bit partial remainder/quotient shift register and a 33-bit subtractor; no internal value exceeds these widths.

Reset
REQ-030 SHALL, on rst=0, force state=IDLE, counter=0, result=0, ready=0 and stall=0 asynchronously, abandoning any operation in flight.
REQ-031 SHALL, after rst rises, accept a start on the first clock edge.

Verification
REQ-032 SHALL cover: unsigned a=100, b=7 → ready in cycle 33, result={0x00000002, 0x0000000E}, stall high for cycles 0..32.
REQ-033 SHALL cover: signed a=-7, b=2 → result={0xFFFFFFFF, 0xFFFFFFFD}; signed a=7, b=-2 → result={0x00000001, 0xFFFFFFFD}.
REQ-034 SHALL cover: signed a=0x80000000, b=0xFFFFFFFF → result={0x00000000, 0x80000000}; unsigned a=0xFFFFFFFF, b=1 → {0, 0xFFFFFFFF}.
REQ-035 SHALL cover: a=5, b=0 → ready the cycle after start, result={0x00000005, 0xFFFFFFFF}, stall high only in the start cycle.
REQ-036 SHALL cover: annul asserted at BUSY counter=10 → IDLE next cycle, no ready, result unchanged; a new start the following cycle completes normally after 33 cycles.
REQ-037 SHALL cover: rst pulsed low mid-BUSY, asynchronously between edges → stall/ready drop immediately, result=0; the next start after release completes correctly.
